// File: rtl/rca16cla.sv
// 16-bit adder built from four 4-bit carry-lookahead slices with inter-slice ripple.
// The sum and carry-out are registered, so results appear one clock after the operands.
module rca16cla (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned SLICE_W    = 4;
    localparam int unsigned NUM_SLICES = WIDTH / SLICE_W;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] sum_c;
    logic             carry_c;

    // Returns {carry_out, sum[3:0]}; each internal carry is a flat sum-of-products.
    function automatic logic [SLICE_W:0] cla_slice(
        input logic [SLICE_W-1:0] sp,
        input logic [SLICE_W-1:0] sg,
        input logic               ci
    );
        logic [SLICE_W:0] c;
        c[0] = ci;
        c[1] = sg[0] | (sp[0] & ci);
        c[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & ci);
        c[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
             | (sp[2] & sp[1] & sp[0] & ci);
        c[4] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
             | (sp[3] & sp[2] & sp[1] & sg[0])
             | (sp[3] & sp[2] & sp[1] & sp[0] & ci);
        return {c[SLICE_W], sp ^ c[SLICE_W-1:0]};
    endfunction

    assign p = a ^ b;
    assign g = a & b;

    // Slice carries ripple: each slice consumes the previous slice's carry-out.
    always_comb begin
        sum_c   = '0;
        carry_c = cin;
        for (int k = 0; k < int'(NUM_SLICES); k++) begin
            {carry_c, sum_c[k*SLICE_W +: SLICE_W]} =
                cla_slice(p[k*SLICE_W +: SLICE_W], g[k*SLICE_W +: SLICE_W], carry_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= sum_c;
            cout <= carry_c;
        end
    end

endmodule

// File: tb/tb_rca16cla.sv
// Scoreboard bench for rca16cla: expected {cout,s} is queued when operands are driven
// and compared one clock later against the registered outputs.
module tb_rca16cla;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;

    logic [16:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    rca16cla dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got {cout,s}=0x%05h expected 0x%05h", tag, obs, exp);
        end
    endtask

    // Drive operands mid-cycle, queue the model result, compare after the next edge.
    task automatic step(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv);
        logic [16:0] exp;
        @(negedge clk);
        a   = av;
        b   = bv;
        cin = cv;
        exp_q.push_back(17'(av) + 17'(bv) + 17'(cv));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {cout, s}, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        a     = 16'hAA2A;
        b     = 16'hCCCC;
        cin   = 1'b1;

        #2;
        check("reset_initial", {cout, s}, 17'h0_0000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", {cout, s}, 17'h0_0000);
        @(negedge clk);
        rst_n = 1'b1;

        step("aa2a_cccc_c1",  16'hAA2A, 16'hCCCC, 1'b1);
        check("aa2a_literal", {cout, s}, 17'h1_76F7);
        step("ffff_0_c1",     16'hFFFF, 16'h0000, 1'b1);
        check("full_ripple_literal", {cout, s}, 17'h1_0000);
        step("slice0_to_1",   16'h000F, 16'h0001, 1'b0);
        check("slice0_to_1_literal", {cout, s}, 17'h0_0010);
        step("slice1_to_2",   16'h00F0, 16'h0010, 1'b0);
        check("slice1_to_2_literal", {cout, s}, 17'h0_0100);
        step("slice2_to_3",   16'h0F00, 16'h0100, 1'b0);
        check("slice2_to_3_literal", {cout, s}, 17'h0_1000);
        step("msb_overflow",  16'h8000, 16'h8000, 1'b0);
        check("msb_overflow_literal", {cout, s}, 17'h1_0000);
        step("all_zero",      16'h0000, 16'h0000, 1'b0);
        check("all_zero_literal", {cout, s}, 17'h0_0000);
        step("max_plus_max",  16'hFFFF, 16'hFFFF, 1'b1);

        // Mid-stream asynchronous reset: clears between edges, then first edge reloads.
        step("pre_reset",     16'hAA2A, 16'hCCCC, 1'b1);
        @(negedge clk);
        a   = 16'h1234;
        b   = 16'h4321;
        cin = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", {cout, s}, 17'h0_0000);
        @(posedge clk);
        #1;
        check("reset_held_edge", {cout, s}, 17'h0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_after_reset", {cout, s}, 17'h0_5556);

        for (int i = 0; i < 10000; i++) begin
            step("random", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rca16cla.md
RCA16CLA -- requirements
Module: rca16cla

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 16 bits and the slice width at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  16  addend A, unsigned.
REQ-005 b  input  16  addend B, unsigned.
REQ-006 cin  input  1  carry-in into bit 0.
REQ-007 s  output  16  registered sum bits [15:0].
REQ-008 cout  output  1  registered carry-out of bit 15.

Function
REQ-009 The block SHALL compute {cout,s} = a + b + cin with full 17-bit precision and no overflow saturation (modulo 2^16 sum plus carry).
REQ-010 The datapath SHALL be four 4-bit carry-lookahead slices: slice k covers bits [4k+3:4k], for k = 0..3.
REQ-011 Per bit i: p[i] = a[i] XOR b[i]; g[i] = a[i] AND b[i]; sum[i] = p[i] XOR c[i].
REQ-012 Within a slice, every internal carry c[i+1] SHALL be a flat two-level lookahead expression of g, p and the slice carry-in; an internal bit-serial ripple is not permitted.
REQ-013 Each slice SHALL also produce a carry-out using the same lookahead form.
REQ-014 Carries SHALL ripple between slices: slice 0 takes cin, and slice k takes the carry-out of slice k-1.
REQ-015 The slice 3 carry-out SHALL be the final carry.
REQ-016 The adder core SHALL be purely combinational, with no latches.
REQ-017 The combinational sum and final carry SHALL be captured into the s and cout registers on every rising clk edge.
REQ-018 Latency SHALL be exactly one clock: operands present before edge N appear on s/cout after edge N. Throughput SHALL be one result per cycle.
REQ-019 There SHALL be no handshake and no enable; inputs are sampled unconditionally on every edge.
REQ-020 Carry-chain boundary: an all-propagate input such as a=0xFFFF, b=0x0000, cin=1 SHALL propagate the carry through all four slices within one cycle.
REQ-021 X/Z on inputs need not be handled; inputs are 2-state.

Reset
REQ-022 While rst_n=0, s SHALL be 0x0000 and cout SHALL be 0, asynchronously and without waiting for a clk edge.
REQ-023 Assertion of rst_n at any time, including mid-stream, SHALL immediately clear s and cout and discard the pending result.
REQ-024 After rst_n deasserts, the first rising edge SHALL load the current a+b+cin.
REQ-025 rst_n deassertion SHALL be treated as synchronous to clk by the integrator; no internal synchronizer is required.

Verification
REQ-026 The bench SHALL drive a=0xAA2A, b=0xCCCC, cin=1, clock once -> s=0x76F7, cout=1.
REQ-027 The bench SHALL drive a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, demonstrating the full inter-slice ripple.
REQ-028 The bench SHALL drive a=0x000F, b=0x0001, cin=0 -> s=0x0010, cout=0, demonstrating the slice 0 to slice 1 carry; repeat at 0x00F0 + 0x0010 -> 0x0100 and at 0x0F00 + 0x0100 -> 0x1000.
REQ-029 The bench SHALL drive a=0x8000, b=0x8000, cin=0 -> s=0x0000, cout=1; and a=0x0000, b=0x0000, cin=0 -> s=0x0000, cout=0.
REQ-030 Reset: with a registered non-zero result (e.g. s=0x76F7), pull rst_n low between clk edges -> s=0x0000 and cout=0 immediately; release -> next edge loads the current sum.
REQ-031 Random test: at least 10,000 random cycles of a, b and cin -> each {cout,s} SHALL equal a+b+cin of the previous cycle, checked against a behavioural 17-bit model.
